// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master that serialises 16-bit register-write
// frames {rw, addr[6:0], wdata[7:0]} MSB first, with a start/busy/done
// handshake, an early-abort path and a guaranteed nCS-high gap between
// frames. Every serial output comes straight from a flop.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4,  // clk cycles per SCLK half-period (4..255)
  parameter int unsigned CS_GAP  = 8   // clk cycles of nCS high after a frame (4..255)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       nCS_out,
  output logic       SCLK_out,
  output logic       COPI_out
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // Terminal counts for the shared phase counter.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  // A full frame has exactly 16 rising SCLK edges.
  localparam logic [4:0] LAST_EDGE = 5'd16;

  state_t      state, state_nx;
  logic [7:0]  phase_cnt, phase_cnt_nx;  // cycles spent in the current half-period / gap
  logic [4:0]  edge_cnt, edge_cnt_nx;    // rising SCLK edges issued this frame
  logic [15:0] shreg, shreg_nx;          // bit 15 is the bit currently on COPI
  logic        busy_nx, done_nx, aborted_nx;
  logic        ncs_nx, sclk_nx, copi_nx;

  logic phase_end;
  logic gap_end;
  logic in_frame;

  assign phase_end = (phase_cnt == DIV_LAST);
  assign gap_end   = (phase_cnt == GAP_LAST);
  assign in_frame  = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and registered outputs, all loaded from the next-state logic.
  // NOTE: the shift register is reset along with the control flops so a
  // frame cut short by reset leaves no stale bits behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      edge_cnt  <= '0;
      shreg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      nCS_out   <= 1'b1;
      SCLK_out  <= 1'b0;
      COPI_out  <= 1'b0;
    end else begin
      phase_cnt <= phase_cnt_nx;
      edge_cnt  <= edge_cnt_nx;
      shreg     <= shreg_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      aborted   <= aborted_nx;
      nCS_out   <= ncs_nx;
      SCLK_out  <= sclk_nx;
      COPI_out  <= copi_nx;
    end
  end

  // Next-state and next-output decode for the frame sequencer.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx     = state;
    phase_cnt_nx = phase_cnt;
    edge_cnt_nx  = edge_cnt;
    shreg_nx     = shreg;
    busy_nx      = busy;
    done_nx      = 1'b0;
    aborted_nx   = aborted;
    ncs_nx       = nCS_out;
    sclk_nx      = SCLK_out;
    copi_nx      = COPI_out;

    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_nx     = {rw, addr, wdata};
          copi_nx      = rw;
          ncs_nx       = 1'b0;
          busy_nx      = 1'b1;
          aborted_nx   = 1'b0;
          phase_cnt_nx = '0;
          edge_cnt_nx  = '0;
          state_nx     = SETUP;
        end
      end

      // First data bit settles on COPI for one low half before SCLK rises.
      SETUP: begin
        if (phase_end) begin
          sclk_nx      = 1'b1;
          edge_cnt_nx  = edge_cnt + 5'd1;
          phase_cnt_nx = '0;
          state_nx     = SHIFT;
        end else begin
          phase_cnt_nx = phase_cnt + 8'd1;
        end
      end

      // COPI changes only together with a falling SCLK edge, so it is stable
      // for a whole half-period on both sides of every rising edge.
      SHIFT: begin
        if (phase_end) begin
          phase_cnt_nx = '0;
          if (SCLK_out) begin
            sclk_nx = 1'b0;
            if (edge_cnt == LAST_EDGE) begin
              copi_nx  = 1'b0;
              state_nx = HOLD;
            end else begin
              shreg_nx = {shreg[14:0], 1'b0};
              copi_nx  = shreg[14];
            end
          end else begin
            sclk_nx     = 1'b1;
            edge_cnt_nx = edge_cnt + 5'd1;
          end
        end else begin
          phase_cnt_nx = phase_cnt + 8'd1;
        end
      end

      // Keep nCS low for one more low half after the last falling edge.
      HOLD: begin
        if (phase_end) begin
          ncs_nx       = 1'b1;
          phase_cnt_nx = '0;
          state_nx     = GAP;
        end else begin
          phase_cnt_nx = phase_cnt + 8'd1;
        end
      end

      // nCS-high recovery time so the peripheral's synchroniser sees the
      // frame end before the next one can begin.
      GAP: begin
        if (gap_end) begin
          busy_nx      = 1'b0;
          done_nx      = 1'b1;
          phase_cnt_nx = '0;
          state_nx     = IDLE;
        end else begin
          phase_cnt_nx = phase_cnt + 8'd1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Abort overrides the normal sequence while the bus is active; the
    // truncated frame still closes through the gap and a flagged done.
    if (abort && in_frame) begin
      sclk_nx      = 1'b0;
      ncs_nx       = 1'b1;
      copi_nx      = 1'b0;
      aborted_nx   = 1'b1;
      phase_cnt_nx = '0;
      state_nx     = GAP;
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller. One instance runs
// with default timing, a second with CLK_DIV=255 / CS_GAP=4. A wire monitor
// collects rising-edge COPI bits, nCS-low / busy / done counts and SCLK
// half-period lengths; the directed steps compare them to hand-computed values.
module tb_spi_controller;

  localparam int CD0 = 4;
  localparam int CG0 = 8;
  localparam int CD1 = 255;
  localparam int CG1 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start_slow;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       abort;

  logic [1:0] busy_o, done_o, abrt_o, ncs_o, sclk_o, copi_o;

  int n_vec = 0;
  int n_err = 0;

  // Wire-monitor state, index 0 = default instance, 1 = slow instance.
  int          rise    [2] = '{0, 0};
  int          ncs_low [2] = '{0, 0};
  int          busy_c  [2] = '{0, 0};
  int          done_c  [2] = '{0, 0};
  logic [31:0] rx      [2] = '{32'h0, 32'h0};
  logic        last_abrt [2] = '{1'b0, 1'b0};
  int          run     [2] = '{0, 0};
  logic        prev_ncs  [2] = '{1'b1, 1'b1};
  logic        prev_sclk [2] = '{1'b0, 1'b0};
  int          hi_min  [2] = '{100000, 100000};
  int          hi_max  [2] = '{0, 0};
  int          lo_min  [2] = '{100000, 100000};
  int          lo_max  [2] = '{0, 0};

  spi_controller u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .abort    (abort),
    .busy     (busy_o[0]),
    .done     (done_o[0]),
    .aborted  (abrt_o[0]),
    .nCS_out  (ncs_o[0]),
    .SCLK_out (sclk_o[0]),
    .COPI_out (copi_o[0])
  );

  spi_controller #(.CLK_DIV(CD1), .CS_GAP(CG1)) u_slow (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_slow),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .abort    (abort),
    .busy     (busy_o[1]),
    .done     (done_o[1]),
    .aborted  (abrt_o[1]),
    .nCS_out  (ncs_o[1]),
    .SCLK_out (sclk_o[1]),
    .COPI_out (copi_o[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic record(input int i, input logic lvl, input int len);
    if (lvl) begin
      if (len < hi_min[i]) hi_min[i] = len;
      if (len > hi_max[i]) hi_max[i] = len;
    end else begin
      if (len < lo_min[i]) lo_min[i] = len;
      if (len > lo_max[i]) lo_max[i] = len;
    end
  endtask

  // Sample all outputs mid-cycle, away from the active clock edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy_o[i]) busy_c[i]++;
      if (!ncs_o[i]) ncs_low[i]++;
      if (done_o[i]) begin
        done_c[i]++;
        last_abrt[i] = abrt_o[i];
      end
      if (sclk_o[i] && !prev_sclk[i]) begin
        rise[i]++;
        rx[i] = {rx[i][30:0], copi_o[i]};
      end
      if (!ncs_o[i]) begin
        if (prev_ncs[i] || (sclk_o[i] != prev_sclk[i])) begin
          if (!prev_ncs[i]) record(i, prev_sclk[i], run[i]);
          run[i] = 1;
        end else begin
          run[i]++;
        end
      end else if (!prev_ncs[i]) begin
        record(i, prev_sclk[i], run[i]);
      end
      prev_ncs[i]  = ncs_o[i];
      prev_sclk[i] = sclk_o[i];
    end
  end

  // One-cycle start pulse; request fields are scrambled afterwards to show
  // they are captured with start.
  task automatic send(input int idx, input logic r, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    rw = r; addr = a; wdata = d;
    if (idx == 0) start = 1'b1; else start_slow = 1'b1;
    @(negedge clk);
    start = 1'b0; start_slow = 1'b0;
    rw = ~r; addr = ~a; wdata = ~d;
  endtask

  // Called on the negedge after start was sampled (lat = 1 there).
  task automatic wait_done(input int idx, input int budget, output int lat);
    logic got;
    got = 1'b0;
    lat = 1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      lat++;
      if (done_o[idx]) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic wait_rises(input int n);
    int   cnt;
    logic prv;
    cnt = 0;
    prv = sclk_o[0];
    for (int k = 0; k < 1000 && cnt < n; k++) begin
      @(negedge clk);
      if (sclk_o[0] && !prv) cnt++;
      prv = sclk_o[0];
    end
    check("rise_wait", cnt, n);
  endtask

  // Full frame on the default instance with all wire-level checks.
  task automatic full_frame(input logic r, input logic [6:0] a, input logic [7:0] d,
                            input logic [15:0] exp_word);
    int s_rise, s_ncs, s_busy, s_done, lat;
    s_rise = rise[0]; s_ncs = ncs_low[0]; s_busy = busy_c[0]; s_done = done_c[0];
    send(0, r, a, d);
    wait_done(0, 400, lat);
    check("done_latency", lat, 33 * CD0 + CG0 + 1);
    @(negedge clk);
    check("rise_count", rise[0] - s_rise, 16);
    check("copi_bits", {16'h0, rx[0][15:0]}, {16'h0, exp_word});
    check("ncs_low_cycles", ncs_low[0] - s_ncs, 33 * CD0);
    check("busy_cycles", busy_c[0] - s_busy, 33 * CD0 + CG0);
    check("done_pulses", done_c[0] - s_done, 1);
    check("aborted_flag", {31'b0, last_abrt[0]}, 32'd0);
  endtask

  initial begin
    int s_rise, s_done, s_ncs, s_busy, lat;
    rst_n = 1'b0; start = 1'b0; start_slow = 1'b0;
    rw = 1'b0; addr = '0; wdata = '0; abort = 1'b0;

    // Reset values.
    #12;
    check("rst_busy", {31'b0, busy_o[0]}, 32'd0);
    check("rst_done", {31'b0, done_o[0]}, 32'd0);
    check("rst_aborted", {31'b0, abrt_o[0]}, 32'd0);
    check("rst_ncs", {31'b0, ncs_o[0]}, 32'd1);
    check("rst_sclk", {31'b0, sclk_o[0]}, 32'd0);
    check("rst_copi", {31'b0, copi_o[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic write frames: 0x80A5, then the loopback register patterns.
    full_frame(1'b1, 7'h00, 8'hA5, 16'h80A5);
    full_frame(1'b1, 7'h04, 8'h80, 16'h8480);
    full_frame(1'b1, 7'h05, 8'hFF, 16'h85FF);
    full_frame(1'b0, 7'h01, 8'h3C, 16'h013C);

    // Start pulses mid-frame are ignored and not queued.
    s_rise = rise[0]; s_done = done_c[0];
    send(0, 1'b1, 7'h10, 8'h01);
    repeat (8) @(negedge clk);
    send(0, 1'b1, 7'h7F, 8'hEE);
    repeat (38) @(negedge clk);
    send(0, 1'b0, 7'h2A, 8'h55);
    wait_done(0, 400, lat);
    @(negedge clk);
    check("ign_rise_count", rise[0] - s_rise, 16);
    check("ign_copi_bits", {16'h0, rx[0][15:0]}, 32'h9001);
    check("ign_done_pulses", done_c[0] - s_done, 1);
    repeat (20) @(negedge clk);
    check("ign_no_queue_busy", {31'b0, busy_o[0]}, 32'd0);
    check("ign_no_queue_ncs", {31'b0, ncs_o[0]}, 32'd1);

    // Start held high through done: second frame begins the cycle after done.
    s_rise = rise[0];
    @(negedge clk);
    rw = 1'b1; addr = 7'h12; wdata = 8'h34; start = 1'b1;
    @(negedge clk);
    rw = 1'b1; addr = 7'h56; wdata = 8'h78;
    wait_done(0, 400, lat);
    check("held_done_latency", lat, 33 * CD0 + CG0 + 1);
    check("held_busy_in_done", {31'b0, busy_o[0]}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("held_busy_next", {31'b0, busy_o[0]}, 32'd1);
    check("held_ncs_next", {31'b0, ncs_o[0]}, 32'd0);
    wait_done(0, 400, lat);
    check("held_second_latency", lat, 33 * CD0 + CG0 + 1);
    @(negedge clk);
    check("held_rise_count", rise[0] - s_rise, 32);
    check("held_copi_bits", rx[0], 32'h9234_D678);

    // Abort in IDLE is ignored.
    s_done = done_c[0];
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (15) @(negedge clk);
    check("idle_abort_done", done_c[0] - s_done, 0);
    check("idle_abort_ncs", {31'b0, ncs_o[0]}, 32'd1);

    // Abort after the 5th rising edge.
    s_rise = rise[0]; s_done = done_c[0];
    send(0, 1'b1, 7'h04, 8'h11);
    wait_rises(5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ncs", {31'b0, ncs_o[0]}, 32'd1);
    check("abort_sclk", {31'b0, sclk_o[0]}, 32'd0);
    check("abort_copi", {31'b0, copi_o[0]}, 32'd0);
    check("abort_busy", {31'b0, busy_o[0]}, 32'd1);
    wait_done(0, 100, lat);
    check("abort_done_latency", lat, CG0 + 1);
    check("abort_aborted_at_done", {31'b0, abrt_o[0]}, 32'd1);
    @(negedge clk);
    check("abort_rise_count", rise[0] - s_rise, 5);
    check("abort_done_pulses", done_c[0] - s_done, 1);
    check("abort_flag_holds", {31'b0, abrt_o[0]}, 32'd1);

    // Next frame clears aborted.
    full_frame(1'b1, 7'h03, 8'hC0, 16'h83C0);

    // Reset after the 9th rising edge, then a clean frame.
    send(0, 1'b1, 7'h22, 8'h5A);
    wait_rises(9);
    rst_n = 1'b0;
    #1;
    check("midrst_ncs", {31'b0, ncs_o[0]}, 32'd1);
    check("midrst_sclk", {31'b0, sclk_o[0]}, 32'd0);
    check("midrst_copi", {31'b0, copi_o[0]}, 32'd0);
    check("midrst_busy", {31'b0, busy_o[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    full_frame(1'b1, 7'h04, 8'h80, 16'h8480);

    // Slowest legal SCLK with shortest gap.
    s_rise = rise[1]; s_ncs = ncs_low[1]; s_busy = busy_c[1];
    send(1, 1'b1, 7'h33, 8'hC3);
    wait_done(1, 9000, lat);
    check("slow_done_latency", lat, 33 * CD1 + CG1 + 1);
    @(negedge clk);
    check("slow_rise_count", rise[1] - s_rise, 16);
    check("slow_copi_bits", {16'h0, rx[1][15:0]}, 32'hB3C3);
    check("slow_ncs_low_cycles", ncs_low[1] - s_ncs, 8415);
    check("slow_busy_cycles", busy_c[1] - s_busy, 8419);
    check("slow_high_min", hi_min[1], CD1);
    check("slow_high_max", hi_max[1], CD1);
    check("slow_low_min", lo_min[1], CD1);
    check("slow_low_max", lo_max[1], CD1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI-mode-0 controller that generates the 16-bit write frames consumed by the on-chip SPI peripheral register file. It sits on the host/test side of the serial link and drives nCS, SCLK and COPI from a parallel request interface with a start/busy/done handshake. Frame format: bit 15 = R/W (1 = write), bits 14:8 = register address, bits 7:0 = data, MSB first. It is the bench and bring-up driver for the register interface and must satisfy the peripheral's 2-flop synchronizer timing.

## Interface
- CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 4..255.
- CS_GAP, default 8: clk cycles nCS is held high after a frame before done; legal range 4..255.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse/level; sampled only when busy = 0.
- rw  input  1  R/W bit for the frame; captured with start.
- addr  input  7  register address; captured with start.
- wdata  input  8  data byte; captured with start.
- abort  input  1  terminate current frame early.
- busy  output  1  frame in progress (including gap).
- done  output  1  one-cycle pulse at end of every accepted frame.
- aborted  output  1  valid with done: 1 if frame ended via abort.
- nCS_out  output  1  chip select, active-low.
- SCLK_out  output  1  serial clock, idle low.
- COPI_out  output  1  serial data to peripheral.

## Operation
- Reset values: busy=0, done=0, aborted=0, nCS_out=1, SCLK_out=0, COPI_out=0; FSM in IDLE; shift register and counters cleared.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: start=1 latches frame={rw,addr,wdata} into 16-bit shift register; next cycle nCS_out=0, COPI_out=frame[15], busy=1, state SETUP.
- SETUP: CLK_DIV cycles, SCLK low; then SCLK_out rises, state SHIFT.
- SHIFT: SCLK toggles every CLK_DIV cycles. On each falling edge the shift register shifts left and COPI_out takes next bit in the same cycle SCLK falls. 5-bit edge counter increments on each rising edge. After the 16th rising edge's high half, SCLK falls and state goes HOLD (no further shift; COPI_out driven 0).
- HOLD: CLK_DIV cycles, nCS low, SCLK low; then nCS_out=1, state GAP.
- GAP: CS_GAP cycles with nCS high; then state IDLE, busy=0, done=1 for one cycle.
- start while busy=1: ignored, not queued.
- start in the done cycle (busy=0): accepted; next frame begins the following cycle.
- abort while in SETUP/SHIFT/HOLD: next cycle SCLK_out=0, nCS_out=1, COPI_out=0, state GAP; done then pulses with aborted=1. abort in IDLE or GAP: ignored. aborted clears on next accepted start.
- Inputs rw/addr/wdata may change freely after the start cycle.
- Asynchronous reset mid-frame: all outputs immediately to reset values; partial frame discarded by peripheral (bit count ≠ 16).

## Timing
- nCS low duration per full frame: 33×CLK_DIV cycles (SETUP 1, 16 high + 15 low halves, HOLD 1).
- SCLK high/low halves exactly CLK_DIV cycles each; exactly 16 rising edges per full frame.
- COPI stable ≥ CLK_DIV cycles before and after every rising SCLK edge.
- busy high exactly 33×CLK_DIV + CS_GAP cycles, starting the cycle after start is sampled.
- done asserted in the first cycle busy is low; minimum start-to-start spacing = 33×CLK_DIV + CS_GAP + 1 cycles.
- Abort: nCS high 1 cycle after abort sampled; done CS_GAP+1 cycles after that.
- All outputs registered; no combinational path from inputs to nCS/SCLK/COPI.

## Test plan
- Write rw=1, addr=0x00, wdata=0xA5, defaults -> COPI sampled on rising edges = 1,0000000,10100101; 16 rising edges; nCS low 132 cycles; busy 140 cycles; one done, aborted=0.
- Loopback to spi_peripheral: write addr 4 data 0x80 -> pwm_duty_cycle=0x80; write addr 5 data 0xFF -> all peripheral registers unchanged; rw=0 addr 1 -> en_reg_out_15_8 unchanged.
- start pulsed at cycles 10 and 50 of a frame -> ignored, exactly one frame on wire; start held high through done -> second frame starts the cycle after done.
- abort after 5th rising edge -> nCS high next cycle, done with aborted=1 after CS_GAP+1 cycles; peripheral registers unchanged.
- rst_n low after 9th rising edge -> nCS=1, SCLK=0, COPI=0, busy=0 immediately; next frame after reset writes correctly.
- CLK_DIV=255, CS_GAP=4 -> half-periods 255 cycles, nCS low 8415 cycles, no counter overflow.
